// File: rtl/spi_pkg.sv
// spi_pkg: types and SCK edge helpers shared by the SPI master and slave.
// Edge helpers take the idle level plus previous/current synchronized SCK.
package spi_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_slv_state_t;

  function automatic logic lead_edge(
    input logic cpol,
    input logic prev,
    input logic cur
  );
    return (prev == cpol) && (cur != cpol);
  endfunction

  function automatic logic trail_edge(
    input logic cpol,
    input logic prev,
    input logic cur
  );
    return (prev != cpol) && (cur == cpol);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// spi_sync: N-stage flop synchronizer with a selectable reset level.
// Ports: clk, rst_n (async low), d (async in), q (synchronized out).
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI responder with rx strobe and tx holding buffer.
// Ports: clk_in/n_rst, SCK/SS/MOSI/MISO/MISO_oe pins, tx ready/valid, rx strobe, status.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                   DATA_BITS = 8,
  parameter bit                   CPOL      = 1'b0,
  parameter bit                   CPHA      = 1'b0,
  parameter bit                   LSBF      = 1'b0,
  parameter logic [DATA_BITS-1:0] FILL      = '0
) (
  input  logic                 clk_in,
  input  logic                 n_rst,
  input  logic                 SCK,
  input  logic                 SS,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MISO_oe,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 tx_underrun,
  output logic                 busy
);

  localparam int CW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

  logic sck_s, ss_s, mosi_s;
  logic sck_d, ss_d;

  spi_sync #(.STAGES(2), .RST_VAL(CPOL)) u_sck (
    .clk(clk_in), .rst_n(n_rst), .d(SCK), .q(sck_s)
  );
  spi_sync #(.STAGES(2), .RST_VAL(1'b1)) u_ss (
    .clk(clk_in), .rst_n(n_rst), .d(SS), .q(ss_s)
  );
  spi_sync #(.STAGES(2), .RST_VAL(1'b0)) u_mosi (
    .clk(clk_in), .rst_n(n_rst), .d(MOSI), .q(mosi_s)
  );

  spi_slv_state_t       state;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] buf_data;
  logic [CW-1:0]        bit_cnt;
  logic                 buf_full;
  logic                 load_pend;
  logic                 fill_pend;

  logic lead, trail, smp, shf;
  logic ss_fall, ss_rise, last_bit, tx_bit;
  logic [DATA_BITS-1:0] rx_next, tx_next, word_src;

  assign lead     = lead_edge(CPOL, sck_d, sck_s);
  assign trail    = trail_edge(CPOL, sck_d, sck_s);
  assign smp      = CPHA ? trail : lead;
  assign shf      = CPHA ? lead : trail;
  assign ss_fall  = ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;
  assign last_bit = (bit_cnt == LAST);

  assign rx_next = LSBF ? {mosi_s, rx_shift[DATA_BITS-1:1]}
                        : {rx_shift[DATA_BITS-2:0], mosi_s};
  assign tx_next = LSBF ? (tx_shift >> 1) : (tx_shift << 1);
  assign word_src = buf_full ? buf_data : FILL;
  assign tx_bit  = LSBF ? tx_shift[0] : tx_shift[DATA_BITS-1];

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      sck_d       <= CPOL;
      ss_d        <= 1'b1;
      rx_shift    <= '0;
      tx_shift    <= '0;
      buf_data    <= '0;
      buf_full    <= 1'b0;
      bit_cnt     <= '0;
      load_pend   <= 1'b0;
      fill_pend   <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      sck_d       <= sck_s;
      ss_d        <= ss_s;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      // Moves only happen with buf_full set, so accept never races a move.
      if (tx_valid && !buf_full) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            state     <= ACTIVE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            fill_pend <= 1'b0;
            if (CPHA) begin
              load_pend <= 1'b1;
            end else begin
              load_pend <= 1'b0;
              tx_shift  <= word_src;
              if (buf_full) buf_full    <= 1'b0;
              else          tx_underrun <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            load_pend <= 1'b0;
            fill_pend <= 1'b0;
          end else if (smp) begin
            rx_shift <= rx_next;
            if (fill_pend) begin
              tx_underrun <= 1'b1;
              fill_pend   <= 1'b0;
            end
            if (last_bit) begin
              rx_data   <= rx_next;
              rx_valid  <= 1'b1;
              bit_cnt   <= '0;
              load_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shf) begin
            if (load_pend) begin
              load_pend <= 1'b0;
              tx_shift  <= word_src;
              // Mode-0 reload happens on the last trailing edge, before the
              // master commits to another word; flag underrun only once the
              // next word actually starts sampling.
              if (buf_full)  buf_full    <= 1'b0;
              else if (CPHA) tx_underrun <= 1'b1;
              else           fill_pend   <= 1'b1;
            end else begin
              tx_shift <= tx_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO_oe  = ~ss_s;
  assign MISO     = ~ss_s & tx_bit;
  assign busy     = ~ss_s;
  assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave in mode 0 and mode 3/LSB-first.
// Two DUTs share the pins; sel steers SS/SCK/tx_valid to one at a time.
module tb_spi_slave;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic sck_pin = 1'b0;
  logic ss_pin = 1'b1;
  logic mosi = 1'b0;
  logic sel = 1'b0;
  logic tv = 1'b0;
  logic [7:0] tx_data = '0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic lsbf = 1'b0;

  always #5 clk = ~clk;

  logic sck0, ss0, tv0, sck3, ss3, tv3;
  logic miso0, oe0, rdy0, rxv0, ur0, busy0;
  logic miso3, oe3, rdy3, rxv3, ur3, busy3;
  logic [7:0] rxd0, rxd3;
  logic miso_w, rdy_w;

  assign sck0   = sel ? 1'b0 : sck_pin;
  assign ss0    = ss_pin | sel;
  assign tv0    = tv & ~sel;
  assign sck3   = sel ? sck_pin : 1'b1;
  assign ss3    = ss_pin | ~sel;
  assign tv3    = tv & sel;
  assign miso_w = sel ? miso3 : miso0;
  assign rdy_w  = sel ? rdy3 : rdy0;

  spi_slave u0 (
    .clk_in(clk), .n_rst(n_rst),
    .SCK(sck0), .SS(ss0), .MOSI(mosi),
    .MISO(miso0), .MISO_oe(oe0),
    .tx_data(tx_data), .tx_valid(tv0), .tx_ready(rdy0),
    .rx_data(rxd0), .rx_valid(rxv0),
    .tx_underrun(ur0), .busy(busy0)
  );

  spi_slave #(.CPOL(1'b1), .CPHA(1'b1), .LSBF(1'b1)) u3 (
    .clk_in(clk), .n_rst(n_rst),
    .SCK(sck3), .SS(ss3), .MOSI(mosi),
    .MISO(miso3), .MISO_oe(oe3),
    .tx_data(tx_data), .tx_valid(tv3), .tx_ready(rdy3),
    .rx_data(rxd3), .rx_valid(rxv3),
    .tx_underrun(ur3), .busy(busy3)
  );

  int n_chk = 0;
  int n_fail = 0;
  int rxv_cnt = 0;
  int ur_cnt = 0;
  logic [7:0] rx_last = '0;
  logic [7:0] rx_prev = '0;

  always @(negedge clk) begin
    if (rxv0 || rxv3) begin
      rxv_cnt <= rxv_cnt + 1;
      rx_prev <= rx_last;
      rx_last <= rxv0 ? rxd0 : rxd3;
    end
    if (ur0 || ur3) ur_cnt <= ur_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    tx_data = d;
    tv = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!rdy_w) ok = 1'b1;
    end
    tv = 1'b0;
    chk("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic ss_low();
    ss_pin = 1'b0;
    half();
  endtask

  task automatic ss_high();
    half();
    ss_pin = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input int nb, input logic [7:0] mo,
                      output logic [7:0] mi);
    int p;
    mi = '0;
    for (int i = 0; i < nb; i++) begin
      p = lsbf ? i : 7 - i;
      if (!cpha) begin
        mosi = mo[p];
        half();
        mi[p] = miso_w;
        sck_pin = ~cpol;
        half();
        sck_pin = cpol;
      end else begin
        sck_pin = ~cpol;
        mosi = mo[p];
        half();
        mi[p] = miso_w;
        sck_pin = cpol;
        half();
      end
    end
    if (!cpha) half();
  endtask

  initial begin
    logic [7:0] mi, mi2;
    int rv0, ur0s;

    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_miso", 32'(miso0), 32'd0);
    chk("rst_oe", 32'(oe0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_rxdata", 32'(rxd0), 32'd0);
    chk("rst_rxv", 32'(rxv0), 32'd0);
    chk("rst_ur", 32'(ur0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);

    // 1: mode 0, preloaded reply
    push(8'h3C);
    chk("t1_ready_low", 32'(rdy0), 32'd0);
    rv0 = rxv_cnt; ur0s = ur_cnt;
    ss_low();
    chk("t1_busy", 32'(busy0), 32'd1);
    xfer(8, 8'hA5, mi);
    ss_high();
    chk("t1_rxcnt", 32'(rxv_cnt - rv0), 32'd1);
    chk("t1_rxdata", 32'(rxd0), 32'hA5);
    chk("t1_miso", 32'(mi), 32'h3C);
    chk("t1_ready", 32'(rdy0), 32'd1);
    chk("t1_ur", 32'(ur_cnt - ur0s), 32'd0);

    // 2: mode 3, LSB first
    sel = 1'b1; cpol = 1'b1; cpha = 1'b1; lsbf = 1'b1;
    sck_pin = 1'b1;
    repeat (4) @(negedge clk);
    push(8'h7E);
    rv0 = rxv_cnt; ur0s = ur_cnt;
    ss_low();
    xfer(8, 8'h81, mi);
    ss_high();
    chk("t2_rxcnt", 32'(rxv_cnt - rv0), 32'd1);
    chk("t2_rxdata", 32'(rxd3), 32'h81);
    chk("t2_miso", 32'(mi), 32'h7E);
    chk("t2_ur", 32'(ur_cnt - ur0s), 32'd0);

    // 3: underrun in mode 0
    sel = 1'b0; cpol = 1'b0; cpha = 1'b0; lsbf = 1'b0;
    sck_pin = 1'b0;
    repeat (4) @(negedge clk);
    rv0 = rxv_cnt; ur0s = ur_cnt;
    ss_low();
    xfer(8, 8'h55, mi);
    ss_high();
    chk("t3_ur", 32'(ur_cnt - ur0s), 32'd1);
    chk("t3_miso", 32'(mi), 32'h00);
    chk("t3_rxdata", 32'(rxd0), 32'h55);
    chk("t3_rxcnt", 32'(rxv_cnt - rv0), 32'd1);

    // 4: back-to-back words without SS toggle
    push(8'hAA);
    rv0 = rxv_cnt; ur0s = ur_cnt;
    ss_low();
    fork
      xfer(8, 8'h12, mi);
      begin
        repeat (20) @(negedge clk);
        push(8'hBB);
      end
    join
    xfer(8, 8'h34, mi2);
    ss_high();
    chk("t4_rxcnt", 32'(rxv_cnt - rv0), 32'd2);
    chk("t4_rx1", 32'(rx_prev), 32'h12);
    chk("t4_rx2", 32'(rx_last), 32'h34);
    chk("t4_miso1", 32'(mi), 32'hAA);
    chk("t4_miso2", 32'(mi2), 32'hBB);
    chk("t4_ur", 32'(ur_cnt - ur0s), 32'd0);

    // 5: abort after 4 bits, then a full word
    rv0 = rxv_cnt;
    ss_low();
    xfer(4, 8'hF0, mi);
    ss_high();
    chk("t5_partial", 32'(rxv_cnt - rv0), 32'd0);
    ss_low();
    xfer(8, 8'hC3, mi);
    ss_high();
    chk("t5_rxcnt", 32'(rxv_cnt - rv0), 32'd1);
    chk("t5_rxdata", 32'(rxd0), 32'hC3);

    // 6: reset mid-word
    push(8'h3C);
    ss_low();
    xfer(4, 8'hFF, mi);
    chk("t6_busy_pre", 32'(busy0), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("t6_miso", 32'(miso0), 32'd0);
    chk("t6_oe", 32'(oe0), 32'd0);
    chk("t6_busy", 32'(busy0), 32'd0);
    chk("t6_ready", 32'(rdy0), 32'd1);
    chk("t6_rxdata", 32'(rxd0), 32'd0);
    chk("t6_rxv", 32'(rxv0), 32'd0);
    ss_pin = 1'b1;
    repeat (4) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    rv0 = rxv_cnt;
    ss_low();
    xfer(8, 8'h99, mi);
    ss_high();
    chk("t6_rxcnt", 32'(rxv_cnt - rv0), 32'd1);
    chk("t6_rxdata2", 32'(rxd0), 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
